alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_shifter.sv | 25 ++
 rtl/alu.sv | 72 +++++++
 tb/tb_alu.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width and the 3-bit opcode encoding used by
// the decode logic and any bench driving the block.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned OP_W      = 3;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_shifter.sv
// Combinational log2(WIDTH)-stage barrel shifter, zero-filling in either
// direction; stage i shifts by 2**i when shamt[i] is set.
module alu_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SH_W  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] din,
    input  logic [SH_W-1:0]  shamt,
    input  logic             left,
    output logic [WIDTH-1:0] result_c
);

    logic [WIDTH-1:0] stage [SH_W+1];

    assign stage[0] = din;

    for (genvar gi = 0; gi < int'(SH_W); gi++) begin : g_stage
        localparam int unsigned STEP = 2 ** gi;
        assign stage[gi+1] = shamt[gi] ? (left ? (stage[gi] << STEP) : (stage[gi] >> STEP))
                                       : stage[gi];
    end

    assign result_c = stage[SH_W];

endmodule : alu_shifter

// File: rtl/alu.sv
// Single-cycle ALU: add/sub, bitwise logic, signed compare and shifts,
// with one registered output stage and synchronous active-high reset.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  control,
    output logic [WIDTH-1:0] dout,
    output logic             cout
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    alu_op_e          op_c;
    logic             sub_c;
    logic [WIDTH-1:0] addend_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] shift_c;
    logic [WIDTH-1:0] result_c;
    logic             carry_c;

    assign op_c = alu_op_e'(control);

    // Subtraction reuses the adder as a + ~b + 1, so carry out means no borrow.
    assign sub_c    = (op_c == ALU_SUB);
    assign addend_c = sub_c ? ~b : b;
    assign sum_c    = (WIDTH+1)'(a) + (WIDTH+1)'(addend_c) + (WIDTH+1)'(sub_c);

    alu_shifter #(
        .WIDTH (WIDTH),
        .SH_W  (SH_W)
    ) u_shifter (
        .din      (a),
        .shamt    (b[SH_W-1:0]),
        .left     (op_c == ALU_SLL),
        .result_c (shift_c)
    );

    // Result/flag select; only ADD and SUB drive a non-zero flag.
    always_comb begin
        result_c = '0;
        carry_c  = 1'b0;
        case (op_c)
            ALU_ADD, ALU_SUB: begin
                result_c = sum_c[WIDTH-1:0];
                carry_c  = sum_c[WIDTH];
            end
            ALU_AND: result_c = a & b;
            ALU_OR:  result_c = a | b;
            ALU_XOR: result_c = a ^ b;
            ALU_SLT: result_c = WIDTH'($signed(a) < $signed(b));
            ALU_SLL, ALU_SRL: result_c = shift_c;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
            cout <= 1'b0;
        end else begin
            dout <= result_c;
            cout <= carry_c;
        end
    end

endmodule : alu

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner vectors, reset/latency
// behaviour, and randomized traffic checked against an arithmetic model.
module tb_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  control;
    logic [31:0] dout;
    logic        cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .control (control),
        .dout    (dout),
        .cout    (cout)
    );

    // Reference: {cout, dout} computed with wide integer arithmetic.
    function automatic logic [32:0] ref_model(input logic [2:0] op, input logic [31:0] x,
                                              input logic [31:0] y);
        longint unsigned ux = longint'(x);
        longint unsigned uy = longint'(y);
        int              sx = x;
        int              sy = y;
        int unsigned     sh = y % 32;
        logic [32:0]     r;
        case (alu_op_e'(op))
            ALU_ADD: r = 33'(ux + uy);
            ALU_SUB: r = {(ux >= uy), 32'(ux - uy)};
            ALU_AND: r = {1'b0, x & y};
            ALU_OR:  r = {1'b0, x | y};
            ALU_XOR: r = {1'b0, x ^ y};
            ALU_SLT: r = {1'b0, 32'(sx < sy)};
            ALU_SLL: r = {1'b0, 32'(ux << sh)};
            default: r = {1'b0, 32'(ux >> sh)};
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed cout/dout=%h expected %h", tag, obs, exp);
        end
    endtask

    // One operation per cycle: drive on negedge, check 1 cycle later, then
    // disturb the inputs mid-cycle and confirm the registered result holds.
    task automatic apply(input string tag, input logic [2:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [32:0] exp);
        @(negedge clk);
        rst     = 1'b0;
        control = op;
        a       = x;
        b       = y;
        @(posedge clk);
        #1;
        chk(tag, {cout, dout}, exp);
        #2;
        a       = ~x;
        b       = $urandom;
        control = 3'($urandom);
        #1;
        chk({tag, "_hold"}, {cout, dout}, exp);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] y;

        rst     = 1'b1;
        control = 3'(ALU_ADD);
        a       = 32'hFFFF_FFFF;
        b       = 32'h0000_0001;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("reset", {cout, dout}, 33'h0);
        end

        // Release reset: the sum of the operands present appears one cycle later.
        apply("add_wrap", 3'(ALU_ADD), 32'hFFFF_FFFF, 32'h0000_0001, {1'b1, 32'h0000_0000});
        apply("add_nc",   3'(ALU_ADD), 32'h0000_000F, 32'hF000_0000, {1'b0, 32'hF000_000F});
        apply("sub_brw",  3'(ALU_SUB), 32'd5, 32'd7, {1'b0, 32'hFFFF_FFFE});
        apply("sub_nb",   3'(ALU_SUB), 32'd7, 32'd5, {1'b1, 32'h0000_0002});
        apply("sub_eq",   3'(ALU_SUB), 32'hF000_000A, 32'hF000_000A, {1'b1, 32'h0});
        apply("slt_neg",  3'(ALU_SLT), 32'h8000_0000, 32'h0000_0001, {1'b0, 32'h1});
        apply("slt_pos",  3'(ALU_SLT), 32'h0000_0001, 32'h8000_0000, {1'b0, 32'h0});
        apply("sll_28",   3'(ALU_SLL), 32'h0000_000F, 32'h0000_001C, {1'b0, 32'hF000_0000});
        apply("srl_4",    3'(ALU_SRL), 32'hF000_0000, 32'hFFFF_FFE4, {1'b0, 32'h0F00_0000});
        apply("sll_0",    3'(ALU_SLL), 32'hDEAD_BEEF, 32'hFFFF_FFE0, {1'b0, 32'hDEAD_BEEF});
        apply("srl_31",   3'(ALU_SRL), 32'h8000_0000, 32'h0000_001F, {1'b0, 32'h0000_0001});
        apply("and",      3'(ALU_AND), 32'hF0F0_1234, 32'hFF00_FF0F, {1'b0, 32'hF000_1204});
        apply("or",       3'(ALU_OR),  32'hF0F0_1234, 32'h0F00_0001, {1'b0, 32'hFFF0_1235});
        apply("xor",      3'(ALU_XOR), 32'hFFFF_0000, 32'hF0F0_F0F0, {1'b0, 32'h0F0F_F0F0});

        // Mid-stream reset discards the pending operation.
        @(negedge clk);
        rst     = 1'b1;
        control = 3'(ALU_ADD);
        a       = 32'h1234_5678;
        b       = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        chk("reset_prio", {cout, dout}, 33'h0);
        apply("post_rst", 3'(ALU_ADD), 32'h1234_5678, 32'hFFFF_FFFF, {1'b1, 32'h1234_5677});

        // Corner-bit space: only the 4 MSBs and 4 LSBs of each operand set.
        for (int o = 0; o < 8; o++) begin
            for (int n = 0; n < 200; n++) begin
                x = {4'($urandom), 24'h0, 4'($urandom)};
                y = {4'($urandom), 24'h0, 4'($urandom)};
                apply("corner", 3'(o), x, y, ref_model(3'(o), x, y));
            end
        end

        // Fully random traffic, back to back.
        for (int n = 0; n < 2000; n++) begin
            op = 3'($urandom);
            x  = $urandom;
            y  = ($urandom_range(0, 3) == 0) ? x : $urandom;
            apply("random", op, x, y, ref_model(op, x, y));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu
